enio_acq_sequencer: RTL and testbench

Command-driven controller that configures and sequences the `hi_enio` sniff/read datapath. Holds the `conf_enio` and `divisor` settings, enables the datapath for a burst of N SSP frames, and adds a settle window before counting and a drain window after it. Sits between the ARM-side command decoder and `hi_enio` in the FPGA top level. The top level synchronizes `ssp_frame` into the `ck_1356meg` domain.

---
 rtl/enio_acq_sequencer_if.sv | 13 +
 rtl/enio_acq_sequencer.sv | 144 ++++++++++++++
 tb/tb_enio_acq_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enio_acq_sequencer_if.sv
// Command channel between the ARM-side command decoder and enio_acq_sequencer.
// The decoder drives valid/op/data; the sequencer answers with ready.
interface enio_acq_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/enio_acq_sequencer.sv
// enio_acq_sequencer: holds the hi_enio configuration and runs one acquisition
// burst per START: settle window, N counted SSP frames, drain window, done pulse.
module enio_acq_sequencer #(
    parameter int SETTLE_CYCLES = 64,
    parameter int DRAIN_CYCLES  = 16,
    parameter int CNT_W         = 16
) (
    input  logic                       ck_1356meg,
    input  logic                       rst,
    enio_acq_sequencer_if.slave        cmd,
    input  logic                       ssp_frame,
    output logic [7:0]                 conf_enio,
    output logic [7:0]                 divisor,
    output logic                       dp_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [CNT_W-1:0]           frames_done
);
    // One down-counter serves both the settle and the drain window; it is
    // loaded with length-1 and the window ends in the cycle it reads zero.
    localparam int TMR_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [7:0]       DIV_RESET   = 8'd95;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM, ST_RUN, ST_DRAIN, ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_SET_MODE = 2'b00,
        OP_SET_DIV  = 2'b01,
        OP_START    = 2'b10,
        OP_ABORT    = 2'b11
    } op_e;

    state_e           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] burst_len;
    logic [CNT_W-1:0] frames_inc;
    logic             ssp_prev;
    op_e              op;
    logic             accept;
    logic             in_burst;
    logic             abort_hit;
    logic             start_hit;
    logic             frame_edge;
    logic             count_hit;
    logic             last_frame;

    assign op            = op_e'(cmd.cmd_op);
    // ABORT is always taken; everything else waits for IDLE.
    assign cmd.cmd_ready = (state == ST_IDLE) | (op == OP_ABORT);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    assign in_burst  = (state == ST_ARM) | (state == ST_RUN) | (state == ST_DRAIN);
    assign abort_hit = accept & (op == OP_ABORT) & in_burst;
    assign start_hit = accept & (op == OP_START);

    // An abort in the same cycle as a frame edge wins; that frame is dropped.
    assign frame_edge = ssp_frame & ~ssp_prev;
    assign count_hit  = (state == ST_RUN) & frame_edge & ~abort_hit;
    assign frames_inc = frames_done + CNT_W'(1);
    assign last_frame = count_hit & (frames_inc == burst_len);

    assign dp_enable = in_burst;
    assign busy      = in_burst;
    assign done      = (state == ST_DONE);

    // State register and window timer.
    always_ff @(posedge ck_1356meg) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Next-state and timer reload; abort overrides any busy-state transition.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            ST_IDLE: begin
                if (start_hit) begin
                    if (cmd.cmd_data == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ARM;
                        tmr_nxt   = SETTLE_LOAD;
                    end
                end
            end
            ST_ARM: begin
                if (tmr == '0) state_nxt = ST_RUN;
                else           tmr_nxt   = tmr - 1'b1;
            end
            ST_RUN: begin
                if (last_frame) begin
                    state_nxt = ST_DRAIN;
                    tmr_nxt   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (tmr == '0) state_nxt = ST_DONE;
                else           tmr_nxt   = tmr - 1'b1;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_DONE;
    end

    // Configuration registers, burst bookkeeping and the frame edge detector.
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            conf_enio   <= 8'h00;
            divisor     <= DIV_RESET;
            burst_len   <= '0;
            frames_done <= '0;
            aborted     <= 1'b0;
            ssp_prev    <= 1'b0;
        end else begin
            ssp_prev <= ssp_frame;
            // Non-ABORT commands are only accepted in IDLE, so config is frozen in a burst.
            if (accept && (op == OP_SET_MODE)) conf_enio <= cmd.cmd_data[7:0];
            if (accept && (op == OP_SET_DIV))  divisor   <= cmd.cmd_data[7:0];
            if (start_hit) begin
                burst_len   <= cmd.cmd_data;
                frames_done <= '0;
                aborted     <= 1'b0;
            end else if (count_hit) begin
                frames_done <= frames_inc;
            end
            if (abort_hit) aborted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_enio_acq_sequencer.sv
// Testbench for enio_acq_sequencer: a vector table for configuration and
// zero-length bursts, hand-written burst sequences, then random traffic
// checked every cycle against a timeline model of the burst.
module tb_enio_acq_sequencer;
    localparam int S = 4;
    localparam int D = 3;
    localparam int W = 16;
    localparam logic [1:0] OP_MODE  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    logic         ck_1356meg = 1'b0;
    logic         rst;
    logic         ssp_frame;
    logic [7:0]   conf_enio;
    logic [7:0]   divisor;
    logic         dp_enable;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] frames_done;

    enio_acq_sequencer_if #(.CNT_W(W)) bus ();

    enio_acq_sequencer #(
        .SETTLE_CYCLES(S),
        .DRAIN_CYCLES (D),
        .CNT_W        (W)
    ) dut (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .cmd        (bus),
        .ssp_frame  (ssp_frame),
        .conf_enio  (conf_enio),
        .divisor    (divisor),
        .dp_enable  (dp_enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .frames_done(frames_done)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    int   n_chk = 0;
    int   n_err = 0;
    logic ready_seen;

    // Timeline model: a burst is described by the cycle it started, the cycle
    // its last frame was counted and the cycle of its done pulse.
    int           cyc       = 0;
    int           m_start   = -1;
    int           m_last    = -1;
    int           m_done_at = -1;
    logic [7:0]   m_conf    = 8'h00;
    logic [7:0]   m_div     = 8'd95;
    logic [W-1:0] m_len     = '0;
    logic [W-1:0] m_frames  = '0;
    logic         m_aborted = 1'b0;
    logic         m_prev    = 1'b0;
    bit           chk_on    = 1'b0;

    typedef struct {
        logic         r;
        logic         v;
        logic [1:0]   op;
        logic [W-1:0] d;
        logic [7:0]   e_conf;
        logic [7:0]   e_div;
        logic         e_busy;
        logic         e_done;
        logic         e_abt;
        logic [W-1:0] e_frames;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_burst();
        return (m_start >= 0) && (cyc > m_start) && ((m_done_at < 0) || (cyc < m_done_at));
    endfunction

    function automatic bit m_idle();
        return !m_in_burst() && (cyc != m_done_at);
    endfunction

    task automatic model_check();
        bit rdy;
        rdy = m_idle() || (bus.cmd_op == OP_ABORT);
        chk("m_ready",   bus.cmd_ready, rdy);
        chk("m_busy",    busy,          m_in_burst());
        chk("m_dp_en",   dp_enable,     m_in_burst());
        chk("m_done",    done,          cyc == m_done_at);
        chk("m_aborted", aborted,       m_aborted);
        chk("m_frames",  frames_done,   m_frames);
        chk("m_conf",    conf_enio,     m_conf);
        chk("m_div",     divisor,       m_div);
    endtask

    task automatic model_step(input logic r, input logic v, input logic [1:0] op,
                              input logic [W-1:0] d, input logic s);
        bit inb, rdy, edge_s, win;
        inb    = m_in_burst();
        rdy    = m_idle() || (op == OP_ABORT);
        edge_s = s && !m_prev;
        win    = inb && (cyc >= m_start + S + 1) && (m_last < 0);
        if (r) begin
            m_conf = 8'h00; m_div = 8'd95; m_len = '0; m_frames = '0;
            m_aborted = 1'b0; m_prev = 1'b0;
            m_start = -1; m_last = -1; m_done_at = -1;
            chk_on = 1'b1;
        end else begin
            m_prev = s;
            if (v && rdy) begin
                case (op)
                    OP_MODE:  m_conf = d[7:0];
                    OP_DIV:   m_div  = d[7:0];
                    OP_START: begin
                        m_len = d; m_frames = '0; m_aborted = 1'b0;
                        m_start = cyc; m_last = -1;
                        m_done_at = (d == '0) ? cyc + 1 : -1;
                    end
                    default: begin
                        if (inb) begin
                            m_aborted = 1'b1;
                            m_done_at = cyc + 1;
                        end
                    end
                endcase
            end else if (win && edge_s) begin
                m_frames = m_frames + 1'b1;
                if (m_frames == m_len) begin
                    m_last    = cyc;
                    m_done_at = cyc + D + 1;
                end
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, check this cycle, advance past the edge.
    task automatic tick(input logic r, input logic v, input logic [1:0] op,
                        input logic [W-1:0] d, input logic s);
        rst = r; bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_data = d; ssp_frame = s;
        #1;
        ready_seen = bus.cmd_ready;
        if (chk_on) model_check();
        @(posedge ck_1356meg);
        model_step(r, v, op, d, s);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] d);
        tick(1'b0, 1'b1, op, d, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   done_cnt;
        int   done_k;
        logic found;
        logic r_i, v_i, s_i;
        logic [1:0] op_i;
        logic [W-1:0] d_i;
        int   sel;

        //            r  v  op        d         conf   div    busy done abt frames
        vecs[0]  = '{1, 0, OP_MODE,  16'h0000, 8'h00, 8'd95, 0,   0,   0,  0};
        vecs[1]  = '{0, 1, OP_MODE,  16'h0001, 8'h01, 8'd95, 0,   0,   0,  0};
        vecs[2]  = '{0, 1, OP_DIV,   16'd39,   8'h01, 8'd39, 0,   0,   0,  0};
        vecs[3]  = '{0, 0, OP_MODE,  16'h00FF, 8'h01, 8'd39, 0,   0,   0,  0};
        vecs[4]  = '{0, 1, OP_ABORT, 16'h0000, 8'h01, 8'd39, 0,   0,   0,  0};
        vecs[5]  = '{1, 1, OP_MODE,  16'h00FF, 8'h00, 8'd95, 0,   0,   0,  0};
        vecs[6]  = '{0, 1, OP_MODE,  16'h0001, 8'h01, 8'd95, 0,   0,   0,  0};
        vecs[7]  = '{0, 1, OP_START, 16'h0000, 8'h01, 8'd95, 0,   1,   0,  0};
        vecs[8]  = '{0, 0, OP_MODE,  16'h0000, 8'h01, 8'd95, 0,   0,   0,  0};
        vecs[9]  = '{0, 1, OP_MODE,  16'hAB12, 8'h12, 8'd95, 0,   0,   0,  0};
        vecs[10] = '{1, 0, OP_MODE,  16'h0000, 8'h00, 8'd95, 0,   0,   0,  0};

        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].d, 1'b0);
            chk($sformatf("v%0d_conf", i),   conf_enio,   vecs[i].e_conf);
            chk($sformatf("v%0d_div", i),    divisor,     vecs[i].e_div);
            chk($sformatf("v%0d_busy", i),   busy,        vecs[i].e_busy);
            chk($sformatf("v%0d_done", i),   done,        vecs[i].e_done);
            chk($sformatf("v%0d_abt", i),    aborted,     vecs[i].e_abt);
            chk($sformatf("v%0d_frames", i), frames_done, vecs[i].e_frames);
        end
        chk("reset_ready", ready_seen, 1'b1);

        // L=3, frame pulse every 8 cycles from N+1; the ARM pulse is ignored.
        cmd(OP_START, 16'd3);
        done_cnt = 0; done_k = -1;
        for (int k = 1; k <= 35; k++) begin
            tick(1'b0, 1'b0, OP_MODE, '0, (k % 8) == 1);
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k + 1;
            end
            if (k + 1 == 5)  chk("t2_arm_pulse_ignored", frames_done, 0);
            if (k + 1 == 10) chk("t2_count1", frames_done, 1);
            if (k + 1 == 18) chk("t2_count2", frames_done, 2);
            if (k + 1 == 26) chk("t2_count3", frames_done, 3);
        end
        chk("t2_done_cycle", done_k, 29);
        chk("t2_done_once", done_cnt, 1);
        chk("t2_not_aborted", aborted, 0);
        chk("t2_frames_hold", frames_done, 3);

        // SET_DIV held off for the whole burst, taken the cycle after done.
        cmd(OP_START, 16'd5);
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            tick(1'b0, 1'b1, OP_DIV, 16'd77, k[0]);
            if (k < 3) chk("t3_ready_low_busy", ready_seen, 0);
            if (done) found = 1'b1;
        end
        chk("t3_done_reached", found, 1);
        chk("t3_div_held", divisor, 95);
        chk("t3_frames", frames_done, 5);
        tick(1'b0, 1'b1, OP_DIV, 16'd77, 1'b0);
        chk("t3_ready_low_in_done", ready_seen, 0);
        chk("t3_div_still", divisor, 95);
        tick(1'b0, 1'b1, OP_DIV, 16'd77, 1'b0);
        chk("t3_ready_idle", ready_seen, 1);
        chk("t3_div_accepted", divisor, 77);

        // ABORT in RUN on the same cycle as a frame edge, after two frames.
        cmd(OP_START, 16'd4);
        for (int k = 1; k <= 9; k++) tick(1'b0, 1'b0, OP_MODE, '0, (k == 6) || (k == 8));
        chk("t4_two_frames", frames_done, 2);
        tick(1'b0, 1'b1, OP_ABORT, '0, 1'b1);
        chk("t4_done", done, 1);
        chk("t4_aborted", aborted, 1);
        chk("t4_frames_kept", frames_done, 2);
        chk("t4_dp_off", dp_enable, 0);
        tick(1'b0, 1'b0, OP_MODE, '0, 1'b0);
        chk("t4_idle_busy", busy, 0);
        chk("t4_done_pulse_ends", done, 0);
        chk("t4_aborted_sticky", aborted, 1);
        cmd(OP_START, 16'd1);
        chk("t4_start_clears_aborted", aborted, 0);
        done_cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(1'b0, 1'b0, OP_MODE, '0, k == 6);
            if (done) done_cnt++;
        end
        chk("t4_second_burst_done", done_cnt, 1);
        chk("t4_second_burst_frames", frames_done, 1);

        // Edge on the RUN entry cycle counts; holding high gives no more counts.
        cmd(OP_START, 16'd2);
        done_k = -1;
        for (int k = 1; k <= 19; k++) begin
            tick(1'b0, 1'b0, OP_MODE, '0, ((k >= 5) && (k <= 12)) || ((k >= 14) && (k <= 16)));
            if (done && done_k < 0) done_k = k + 1;
            if (k == 5)  chk("t6_entry_edge_counted", frames_done, 1);
            if (k == 12) chk("t6_held_high_one_count", frames_done, 1);
            if (k == 14) chk("t6_second_edge", frames_done, 2);
        end
        chk("t6_done_cycle", done_k, 18);

        // Edge in the last ARM cycle, held into RUN, is never counted.
        cmd(OP_START, 16'd2);
        for (int k = 1; k <= 8; k++) tick(1'b0, 1'b0, OP_MODE, '0, k >= 4);
        chk("t7_last_arm_edge_ignored", frames_done, 0);
        chk("t7_still_busy", busy, 1);
        tick(1'b0, 1'b1, OP_ABORT, '0, 1'b0);
        tick(1'b0, 1'b0, OP_MODE, '0, 1'b0);
        chk("t7_back_idle", busy, 0);

        // Random traffic against the timeline model.
        tick(1'b1, 1'b0, OP_MODE, '0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r_i = ($urandom_range(0, 299) == 0);
            v_i = ($urandom_range(0, 3) == 0);
            s_i = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 9);
            if (sel <= 2)      op_i = OP_MODE;
            else if (sel <= 4) op_i = OP_DIV;
            else if (sel <= 8) op_i = OP_START;
            else               op_i = OP_ABORT;
            if (op_i == OP_START) d_i = W'($urandom_range(0, 5));
            else                  d_i = W'($urandom);
            tick(r_i, v_i, op_i, d_i, s_i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
